div_unit: RTL
=============

# div_unit

Iterative 32-bit signed/unsigned divider in the EX stage of the MIPS pipeline. It consumes `alucontrol` from the ALU decoder and starts on `DIV_CONTROL` or `DIVU_CONTROL`. It stalls the pipeline while iterating and returns `{hi, lo} = {remainder, quotient}` for the HI/LO register write. It uses a radix-2 restoring algorithm over exactly 32 iterations.

## Interface
Parameters:
- `WIDTH`, 32: operand width. Only 32 is supported; the HI/LO result is `2*WIDTH`.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `alucontrol`  in  5  EX-stage ALU control code.
- `valid_i`  in  1  the EX-stage instruction is live (not a bubble).
- `annul_i`  in  1  flush (exception or eret). Aborts any division in flight.
- `a_i`  in  32  dividend (rs).
- `b_i`  in  32  divisor (rt).
- `stall_o`  out  1  hold IF/ID/EX. Reset value 0.
- `ready_o`  out  1  result valid this cycle. Reset value 0.
- `result_o`  out  64  `{hi = remainder, lo = quotient}`. Reset value 0.

## Operation
- start = `valid_i & ~annul_i & (alucontrol == DIV_CONTROL | alucontrol == DIVU_CONTROL)`, sampled only in IDLE.
- signed = (`alucontrol == DIV_CONTROL`).
- States: IDLE, BUSY, DONE, plus ZERO when `DIV_BYZERO_EN` is defined.
- IDLE + start:
  - Latch |a| and |b| (magnitudes only when signed).
  - Latch sign_q = a[31]^b[31] and sign_r = a[31] (both forced to 0 when unsigned).
  - Clear the partial remainder and `cnt`, then go to BUSY.
- BUSY, each cycle:
  - Shift {rem, quot} left by 1 and trial-subtract the divisor from the upper half.
  - If the result is non-negative, keep it and set quotient bit 0 to 1.
  - `cnt++`. When `cnt == 31`, go to DONE.
- Entering DONE:
  - `result_o` = {sign_r ? -rem : rem, sign_q ? -quot : quot}, with 32-bit two's-complement wrap.
  - DONE then goes to IDLE unconditionally. A start seen in DONE is ignored.
- Signed overflow 0x80000000 / -1 → lo = 0x80000000, hi = 0. No exception is raised.
- `annul_i` in any state → IDLE next edge, and `ready_o` stays 0. `rst` behaves identically and also clears `result_o`.
- `result_o` holds its last value after DONE until the next completion.

## Timing
- Start accepted at cycle T → BUSY during T+1..T+32 → DONE at T+33, with `ready_o` = 1 for exactly that one cycle.
- `stall_o` = (IDLE & start) | BUSY, combinationally. It is high during T..T+32 and low in DONE, so EX advances at the end of T+33.
- Latency is 33 cycles from start to `ready_o`. Throughput is one division per 34 cycles minimum.
- Non-divide `alucontrol` values never assert `stall_o` or `ready_o`.

## Configuration
- `DIV_BYZERO_EN`, when defined:
  - `b_i == 0` at start goes to ZERO instead of BUSY.
  - ZERO behaves like DONE: `ready_o` = 1 at T+1 and `stall_o` is high only at T.
  - Result: hi = `a_i`, lo = 0xFFFFFFFF, for both signed and unsigned.
- When undefined:
  - Division by zero runs the full 33 cycles and returns the datapath's natural result.
  - Unsigned: hi = a, lo = 0xFFFFFFFF.
  - Signed: hi = a; lo = 0xFFFFFFFF for a ≥ 0, or 0x00000001 for a < 0.

## Structure
- `DIV_CONTROL`, `DIVU_CONTROL` and the state encodings (`DIV_IDLE`, `DIV_BUSY`, `DIV_DONE`, `DIV_ZERO`) belong in `defines.vh`.
- Sub-module `div_step` is combinational and implements one restoring iteration: (rem, quot, divisor) → (rem', quot'). It is instantiated once and used every BUSY cycle.
- `div_unit` owns the FSM, counter, sign handling and stall logic.

## Test plan
- DIVU 100 / 7 started at T → `stall_o` high T..T+32, `ready_o` at T+33, result hi = 2, lo = 14.
- DIV -7 / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIV 7 / -2 → lo = 0xFFFFFFFD, hi = 0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0, with no hang or extra cycles.
- Division by zero:
  - DIVU 5 / 0 with `DIV_BYZERO_EN` → `ready_o` at T+1, hi = 5, lo = 0xFFFFFFFF.
  - DIVU 5 / 0 without the macro → `ready_o` at T+33, same values.
  - DIV -5 / 0 without the macro → lo = 0x00000001.
- `annul_i` at T+10 → IDLE at T+11 and `ready_o` never asserts. A new DIVU 9 / 3 at T+12 → `ready_o` at T+45, lo = 3, hi = 0.
- `rst` at T+20 → all outputs 0 next cycle. Back-to-back DIVs in consecutive EX instructions each complete with a 34-cycle spacing.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared definitions for the EX-stage divider: ALU control codes for DIV/DIVU,
// FSM state encodings and sign helpers. The DIV_ZERO state is only reachable
// when the design is built with DIV_BYZERO_EN.
package div_unit_pkg;

  localparam int DIV_W = 32;

  // ALU decoder codes that select the divider
  localparam logic [4:0] DIV_CONTROL  = 5'b10110;
  localparam logic [4:0] DIVU_CONTROL = 5'b10111;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2,
    DIV_ZERO = 2'd3
  } div_state_e;

  // Magnitude of a two's-complement value when en is set, raw bits otherwise
  function automatic logic [DIV_W-1:0] abs_if(input logic [DIV_W-1:0] v, input logic en);
    return (en && v[DIV_W-1]) ? (~v + 1'b1) : v;
  endfunction

  // Conditional two's-complement negate with natural 32-bit wrap
  function automatic logic [DIV_W-1:0] neg_if(input logic [DIV_W-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// EX-stage divider request/response bundle. The pipeline side drives the
// master modport, the divider sits on the slave modport.
interface div_unit_if;
  import div_unit_pkg::*;

  logic [4:0]         alucontrol;
  logic               valid_i;
  logic               annul_i;
  logic [DIV_W-1:0]   a_i;
  logic [DIV_W-1:0]   b_i;
  logic               stall_o;
  logic               ready_o;
  logic [2*DIV_W-1:0] result_o;

  modport master (
    output alucontrol, valid_i, annul_i, a_i, b_i,
    input  stall_o, ready_o, result_o
  );

  modport slave (
    input  alucontrol, valid_i, annul_i, a_i, b_i,
    output stall_o, ready_o, result_o
  );

endinterface

// File: rtl/div_step.sv
// One radix-2 restoring division iteration, purely combinational.
// {rem, quot} is shifted left by one, the divisor is trial-subtracted from the
// upper half, and the subtraction is kept only when it does not go negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quot,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quot_next
);

  // The shifted remainder needs one extra bit; the difference needs a second
  // extra bit so its sign is unambiguous.
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH+1:0] diff;
  logic             fits;
  logic             diff_top_unused;

  assign rem_shift = {rem, quot[WIDTH-1]};
  assign diff      = {1'b0, rem_shift} - {2'b00, divisor};
  assign fits      = ~diff[WIDTH+1];

  // A kept difference is always below the divisor, so its bit WIDTH is zero
  assign diff_top_unused = diff[WIDTH];

  // Restore or keep the trial subtraction and shift in the new quotient bit
  always_comb begin
    rem_next  = fits ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quot_next = {quot[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit signed/unsigned divider for the MIPS EX stage.
// Stalls the pipeline for 32 restoring iterations and returns
// {hi, lo} = {remainder, quotient}. Optional build macro DIV_BYZERO_EN
// short-circuits division by zero through a one-cycle ZERO state.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input logic      clk,
  input logic      rst,
  div_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  div_state_e         state_reg, state_next;
  logic [WIDTH-1:0]   rem_reg, rem_next;
  logic [WIDTH-1:0]   quot_reg, quot_next;
  logic [WIDTH-1:0]   divisor_reg, divisor_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic               sign_q_reg, sign_q_next;
  logic               sign_r_reg, sign_r_next;
  logic [2*WIDTH-1:0] result_reg, result_next;

  logic               is_signed;
  logic               is_div;
  logic               start;
  logic [WIDTH-1:0]   step_rem;
  logic [WIDTH-1:0]   step_quot;

  assign is_signed = (bus.alucontrol == DIV_CONTROL);
  assign is_div    = is_signed | (bus.alucontrol == DIVU_CONTROL);
  assign start     = bus.valid_i & ~bus.annul_i & is_div;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem       (rem_reg),
    .quot      (quot_reg),
    .divisor   (divisor_reg),
    .rem_next  (step_rem),
    .quot_next (step_quot)
  );

  // Next-state, datapath load and result capture
  always_comb begin
    state_next   = state_reg;
    rem_next     = rem_reg;
    quot_next    = quot_reg;
    divisor_next = divisor_reg;
    cnt_next     = cnt_reg;
    sign_q_next  = sign_q_reg;
    sign_r_next  = sign_r_reg;
    result_next  = result_reg;

    case (state_reg)
      DIV_IDLE: begin
        if (start) begin
          // Dividend magnitude is loaded into the quotient half; it is shifted
          // out into the remainder one bit per iteration.
          quot_next    = abs_if(bus.a_i, is_signed);
          divisor_next = abs_if(bus.b_i, is_signed);
          rem_next     = '0;
          cnt_next     = '0;
          sign_q_next  = is_signed & (bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1]);
          sign_r_next  = is_signed & bus.a_i[WIDTH-1];
          state_next   = DIV_BUSY;
`ifdef DIV_BYZERO_EN
          if (bus.b_i == '0) begin
            state_next  = DIV_ZERO;
            result_next = {bus.a_i, {WIDTH{1'b1}}};
          end
`endif
        end
      end

      DIV_BUSY: begin
        rem_next  = step_rem;
        quot_next = step_quot;
        cnt_next  = cnt_reg + 1'b1;
        if (cnt_reg == CNT_LAST) begin
          state_next  = DIV_DONE;
          // Remainder takes the dividend sign, quotient the xor of both signs
          result_next = {neg_if(step_rem, sign_r_reg), neg_if(step_quot, sign_q_reg)};
        end
      end

      DIV_DONE: state_next = DIV_IDLE;

`ifdef DIV_BYZERO_EN
      DIV_ZERO: state_next = DIV_IDLE;
`endif

      default: state_next = DIV_IDLE;
    endcase

    // A flush abandons the division without touching the visible result
    if (bus.annul_i) begin
      state_next  = DIV_IDLE;
      result_next = result_reg;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= DIV_IDLE;
      rem_reg     <= '0;
      quot_reg    <= '0;
      divisor_reg <= '0;
      cnt_reg     <= '0;
      sign_q_reg  <= 1'b0;
      sign_r_reg  <= 1'b0;
      result_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      rem_reg     <= rem_next;
      quot_reg    <= quot_next;
      divisor_reg <= divisor_next;
      cnt_reg     <= cnt_next;
      sign_q_reg  <= sign_q_next;
      sign_r_reg  <= sign_r_next;
      result_reg  <= result_next;
    end
  end

  // Stall covers the accepting cycle and every iteration; DONE releases EX
  always_comb begin
    bus.stall_o  = ((state_reg == DIV_IDLE) & start) | (state_reg == DIV_BUSY);
`ifdef DIV_BYZERO_EN
    bus.ready_o  = (state_reg == DIV_DONE) | (state_reg == DIV_ZERO);
`else
    bus.ready_o  = (state_reg == DIV_DONE);
`endif
    bus.result_o = result_reg;
  end

endmodule
